axa_undo_rollback: RTL and testbench

Rollback engine for the AXA pipelined processor: the reader side of the undo stack. The ALU stage pushes `{kind, reg, old value}` entries as it overwrites registers. On a rollback request (the `jerr` path), this block pops entries one at a time through a request/valid handshake and replays each saved value into the register file. It stops at the first `land` marker and hands that marker's PC to the fetch stage; the pipeline stalls while `busy` is high.

---
 rtl/axa_undo_pkg.sv | 37 +++
 rtl/axa_undo_rollback.sv | 118 +++++++++++
 tb/tb_axa_undo_rollback.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axa_undo_pkg.sv
// Shared definitions for the AXA undo stack (push side in the ALU stage and
// the rollback reader).
//   - Entry layout: [21:20] kind, [19:16] register, [15:0] saved value.
//   - Kind encodings: REG restores a register, LAND marks the rollback target.
//   - Rollback FSM state encodings.
package axa_undo_pkg;

  localparam int unsigned ENTRY_W  = 22;
  localparam int unsigned KIND_W   = 2;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned VAL_W    = 16;
  localparam int unsigned KIND_LSB = 20;
  localparam int unsigned REG_LSB  = 16;
  localparam int unsigned VAL_LSB  = 0;

  // 2'b10 and 2'b11 are invalid kinds and are not named here.
  typedef enum logic [KIND_W-1:0] {
    KIND_REG  = 2'b00,
    KIND_LAND = 2'b01
  } kind_e;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [REG_W-1:0]  rf_reg;
    logic [VAL_W-1:0]  value;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_WRITE,
    ST_FINISH,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/axa_undo_rollback.sv
// Rollback engine: reader side of the undo stack.
// Pops entries through a req/valid handshake, replays each saved REG value
// into the register file and stops at the first LAND marker, whose value is
// loaded into the fetch PC.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   rb_start          rollback request (sampled only in IDLE)
//   stack_empty       undo stack holds no entries
//   pop_valid/pop_data popped entry from the stack
//   pop_req           pop request (combinational from state)
//   busy              rollback in progress (combinational from state)
//   rf_we/rf_addr/rf_data register-file restore port
//   pc_we/pc_out      fetch PC load
//   done              one-cycle completion pulse
//   fault             sticky error flag, held until reset
//   rb_count          REG entries restored in the last/current rollback
module axa_undo_rollback
  import axa_undo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rb_start,
  input  logic               stack_empty,
  input  logic               pop_valid,
  input  logic [ENTRY_W-1:0] pop_data,
  output logic               pop_req,
  output logic               busy,
  output logic               rf_we,
  output logic [REG_W-1:0]   rf_addr,
  output logic [VAL_W-1:0]   rf_data,
  output logic               pc_we,
  output logic [VAL_W-1:0]   pc_out,
  output logic               done,
  output logic               fault,
  output logic [4:0]         rb_count
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [4:0] COUNT_MAX = 5'(DEPTH);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt;
  entry_t     ent;
  logic       timeout_hit;

  assign ent         = entry_t'(pop_data);
  assign timeout_hit = (wait_cnt == WAIT_LAST);

  assign pop_req = (state_q == ST_POP) && !stack_empty;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FAULT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rb_start) state_d = ST_POP;
      ST_POP:    state_d = stack_empty ? ST_FAULT : ST_WAIT;
      ST_WAIT: begin
        if (pop_valid) begin
          if (ent.kind == KIND_REG)       state_d = ST_WRITE;
          else if (ent.kind == KIND_LAND) state_d = ST_FINISH;
          else                            state_d = ST_FAULT;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_WRITE:  state_d = ST_POP;
      ST_FINISH: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are high exactly
  // while the FSM sits in WRITE / FINISH / FAULT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wait_cnt <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      pc_we    <= 1'b0;
      pc_out   <= '0;
      done     <= 1'b0;
      fault    <= 1'b0;
      rb_count <= '0;
    end else begin
      state_q <= state_d;
      rf_we   <= (state_d == ST_WRITE);
      pc_we   <= (state_d == ST_FINISH);
      done    <= (state_d == ST_FINISH);
      if (state_d == ST_FAULT) fault <= 1'b1;

      if (state_q == ST_POP)
        wait_cnt <= '0;
      else if (state_q == ST_WAIT && !pop_valid)
        wait_cnt <= wait_cnt + 8'd1;

      if (state_q == ST_WAIT && pop_valid) begin
        if (ent.kind == KIND_REG) begin
          rf_addr <= ent.rf_reg;
          rf_data <= ent.value;
        end else if (ent.kind == KIND_LAND) begin
          pc_out <= ent.value;
        end
      end

      if (state_q == ST_IDLE && rb_start)
        rb_count <= '0;
      else if (state_q == ST_WRITE && rb_count != COUNT_MAX)
        rb_count <= rb_count + 5'd1;
    end
  end

endmodule

// File: tb/tb_axa_undo_rollback.sv
module tb_axa_undo_rollback;
  import axa_undo_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               rb_start = 1'b0;
  logic               stack_empty = 1'b0;
  logic               pop_valid = 1'b0;
  logic [ENTRY_W-1:0] pop_data = '0;
  logic               pop_req, busy, rf_we, pc_we, done, fault;
  logic [3:0]         rf_addr;
  logic [15:0]        rf_data, pc_out;
  logic [4:0]         rb_count;

  int unsigned tests = 0;
  int unsigned failures = 0;

  axa_undo_rollback #(.TIMEOUT(6), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rb_start(rb_start), .stack_empty(stack_empty),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_req(pop_req), .busy(busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .pc_we(pc_we),
    .pc_out(pc_out), .done(done), .fault(fault), .rb_count(rb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge: one bench cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".pop_req"},  32'(pop_req),  0);
    check({tag, ".busy"},     32'(busy),     0);
    check({tag, ".rf_we"},    32'(rf_we),    0);
    check({tag, ".pc_we"},    32'(pc_we),    0);
    check({tag, ".done"},     32'(done),     0);
    check({tag, ".fault"},    32'(fault),    0);
    check({tag, ".rf_addr"},  32'(rf_addr),  0);
    check({tag, ".rf_data"},  32'(rf_data),  0);
    check({tag, ".pc_out"},   32'(pc_out),   0);
    check({tag, ".rb_count"}, 32'(rb_count), 0);
  endtask

  // Pulse reset mid-cycle, release it mid-cycle, and return at the start
  // of a fresh cycle (cycle 0 of the next scenario).
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_idle(tag);
    rb_start    = 1'b0;
    pop_valid   = 1'b0;
    stack_empty = 1'b0;
    @(negedge clk) reset = 1'b0;
    tick();
  endtask

  // Nominal stack: REG(r3,1234), REG(r7,BEEF), LAND(0040), zero-wait.
  task automatic run_nominal(input string tag, input bit overlap);
    rb_start = 1'b1;                                   // cycle 0
    tick(); rb_start = 1'b0;                           // cycle 1 POP
    check({tag, ".c1.pop_req"}, 32'(pop_req), 1);
    check({tag, ".c1.busy"},    32'(busy),    1);
    tick();                                            // cycle 2 WAIT
    pop_valid = 1'b1; pop_data = {2'b00, 4'd3, 16'h1234};
    check({tag, ".c2.pop_req"}, 32'(pop_req), 0);
    tick(); pop_valid = 1'b0;                          // cycle 3 WRITE
    check({tag, ".c3.rf_we"},   32'(rf_we),   1);
    check({tag, ".c3.rf_addr"}, 32'(rf_addr), 3);
    check({tag, ".c3.rf_data"}, 32'(rf_data), 32'h1234);
    tick();                                            // cycle 4 POP
    if (overlap) rb_start = 1'b1;
    check({tag, ".c4.pop_req"}, 32'(pop_req), 1);
    check({tag, ".c4.rf_we"},   32'(rf_we),   0);
    tick(); rb_start = 1'b0;                           // cycle 5 WAIT
    pop_valid = 1'b1; pop_data = {2'b00, 4'd7, 16'hBEEF};
    check({tag, ".c5.rb_count"}, 32'(rb_count), 1);
    tick(); pop_valid = 1'b0;                          // cycle 6 WRITE
    check({tag, ".c6.rf_we"},   32'(rf_we),   1);
    check({tag, ".c6.rf_addr"}, 32'(rf_addr), 7);
    check({tag, ".c6.rf_data"}, 32'(rf_data), 32'hBEEF);
    tick();                                            // cycle 7 POP
    check({tag, ".c7.pop_req"}, 32'(pop_req), 1);
    tick();                                            // cycle 8 WAIT
    pop_valid = 1'b1; pop_data = {2'b01, 4'd0, 16'h0040};
    check({tag, ".c8.done"}, 32'(done), 0);
    tick(); pop_valid = 1'b0;                          // cycle 9 FINISH
    check({tag, ".c9.pc_we"},    32'(pc_we),    1);
    check({tag, ".c9.pc_out"},   32'(pc_out),   32'h0040);
    check({tag, ".c9.done"},     32'(done),     1);
    check({tag, ".c9.rb_count"}, 32'(rb_count), 2);
    check({tag, ".c9.rf_we"},    32'(rf_we),    0);
    tick();                                            // cycle 10 IDLE
    check({tag, ".c10.done"},    32'(done),    0);
    check({tag, ".c10.busy"},    32'(busy),    0);
    check({tag, ".c10.pop_req"}, 32'(pop_req), 0);
    check({tag, ".c10.fault"},   32'(fault),   0);
  endtask

  initial begin
    // Reset values while reset is held from time 0.
    #2 check_idle("rst_init");
    @(negedge clk) reset = 1'b0;
    tick();

    run_nominal("nominal", 1'b0);
    tick();
    run_nominal("overlap", 1'b1);
    tick();

    // Asynchronous reset while pop_req is high in POP.
    rb_start = 1'b1;
    tick(); rb_start = 1'b0;
    check("async.pop_req_before", 32'(pop_req), 1);
    do_reset("async");

    // Abort: reset during the WAIT for the r7 entry (cycle 5).
    rb_start = 1'b1;
    tick(); rb_start = 1'b0;                           // 1
    tick(); pop_valid = 1'b1; pop_data = {2'b00, 4'd3, 16'h1234}; // 2
    tick(); pop_valid = 1'b0;                          // 3
    check("abort.c3.rf_we", 32'(rf_we), 1);
    tick();                                            // 4
    tick(); pop_valid = 1'b1; pop_data = {2'b00, 4'd7, 16'hBEEF}; // 5
    check("abort.c5.busy", 32'(busy), 1);
    do_reset("abort");
    check("abort.after.rf_we", 32'(rf_we), 0);
    check("abort.after.busy",  32'(busy),  0);
    tick();
    check("abort.after2.rf_we",   32'(rf_we),   0);
    check("abort.after2.rf_addr", 32'(rf_addr), 0);

    // Empty stack.
    stack_empty = 1'b1;
    rb_start = 1'b1;
    tick(); rb_start = 1'b0;                           // 1 POP
    check("empty.c1.pop_req", 32'(pop_req), 0);
    check("empty.c1.busy",    32'(busy),    1);
    tick();                                            // 2 FAULT
    check("empty.c2.fault",   32'(fault),   1);
    check("empty.c2.busy",    32'(busy),    0);
    check("empty.c2.pop_req", 32'(pop_req), 0);
    rb_start = 1'b1;
    tick(); rb_start = 1'b0;
    tick();
    check("empty.sticky.fault", 32'(fault), 1);
    check("empty.sticky.busy",  32'(busy),  0);
    do_reset("empty_rst");

    // Timeout (TIMEOUT = 6): WAIT cycles 2..7, FAULT at cycle 8.
    rb_start = 1'b1;
    tick(); rb_start = 1'b0;                           // 1 POP
    check("tmo.c1.pop_req", 32'(pop_req), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("tmo.c%0d.fault", i + 2), 32'(fault), 0);
      check($sformatf("tmo.c%0d.rf_we", i + 2), 32'(rf_we), 0);
      check($sformatf("tmo.c%0d.busy",  i + 2), 32'(busy),  1);
    end
    tick();                                            // 8
    check("tmo.c8.fault", 32'(fault), 1);
    check("tmo.c8.busy",  32'(busy),  0);
    check("tmo.c8.rf_we", 32'(rf_we), 0);
    do_reset("tmo_rst");

    // Invalid kind 2'b11 on the top entry.
    rb_start = 1'b1;
    tick(); rb_start = 1'b0;                           // 1
    tick(); pop_valid = 1'b1; pop_data = {2'b11, 4'd5, 16'hAAAA}; // 2
    tick(); pop_valid = 1'b0;                          // 3
    check("bad.c3.fault",    32'(fault),    1);
    check("bad.c3.rf_we",    32'(rf_we),    0);
    check("bad.c3.rb_count", 32'(rb_count), 0);
    check("bad.c3.rf_addr",  32'(rf_addr),  0);
    check("bad.c3.busy",     32'(busy),     0);
    tick();
    check("bad.c4.fault",    32'(fault),    1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
